shared_mem_arbiter: RTL and testbench
=====================================

# shared_mem_arbiter

Round-robin arbiter placed directly upstream of `shared_memory` in the CGRA. It gives `N_PE` processing elements pipelined access to the single-port shared memory. Each PE sees a valid/ready request channel and a response pulse; the block owns the memory's command inputs and routes the registered `read_data` back to the requester. Throughput is one memory operation per cycle.

## Interface
Parameters:
- `N_PE`, 4: number of PE request ports (2..8).
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: address width (word index).
- `MEM_DEPTH`, 256: number of memory words.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_PE: per-PE request valid.
- `req_ready` out N_PE: per-PE accept, combinational, one-hot or zero.
- `req_write` in N_PE: 1 = write, 0 = read.
- `req_addr` in N_PE*ADDR_W: PE i occupies slice [i*ADDR_W +: ADDR_W].
- `req_wdata` in N_PE*DATA_W: packed like `req_addr`.
- `resp_valid` out N_PE: one-cycle completion pulse per PE.
- `resp_rdata` out DATA_W: read data shared by all PEs, qualified by `resp_valid`.
- `resp_err` out 1: out-of-range flag, qualified by `resp_valid`.
- `mem_address` out ADDR_W: to memory `address`.
- `mem_write_data` out DATA_W: to memory `write_data`.
- `mem_read` out 1: to memory `mem_read`.
- `mem_write` out 1: to memory `mem_write`.
- `mem_read_data` in DATA_W: from memory `read_data`, valid the cycle after the memory samples `mem_read`.

## Operation
**Arbitration**
- Round-robin pointer `last_grant` (log2 N_PE bits). Priority scan starts at `last_grant+1` and wraps modulo `N_PE`.
- Exactly one `req_ready` is asserted, to the first PE in scan order with `req_valid`=1. `req_ready` does not depend on the PE's own `req_ready`.
- A transfer happens when `req_valid & req_ready` at a rising edge. On a transfer, `last_grant` takes the winner index. With no transfer, the pointer holds.
- A PE must hold its request stable until it is accepted. The arbiter never stalls, because the memory is always ready.

**Stage 1 (command register)**
- On a transfer, `mem_address`, `mem_write_data`, `mem_read`=!write and `mem_write`=write are registered, together with the requester index and a `wr` flag.
- With no transfer, `mem_read` and `mem_write` register 0. Address and data hold their previous values.

**Stage 2 (response tag)**
- One cycle after stage 1, a valid/index/wr/err tag moves to stage 2.
- `resp_valid[idx]` is driven from the stage-2 tag.
- Reads: `resp_rdata` = `mem_read_data`.
- Writes: `resp_rdata` = 0. The write acknowledge still pulses `resp_valid`.

**Reset**
- All outputs are 0 during and after reset: `req_ready` is 0 while `rst`=1, and `mem_*`, `resp_*` and both pipeline tags are 0.
- `last_grant` resets to `N_PE-1`, so PE0 has first priority.
- Asserting reset mid-operation drops in-flight requests. No `resp_valid` appears for them after reset.

## Timing
- Request accepted at edge T. Memory command is visible during cycle T+1. Memory executes at edge T+1. `resp_valid` and `resp_rdata` are valid during cycle T+2, giving a 2-cycle latency.
- Back-to-back transfers on consecutive edges produce consecutive `resp_valid` pulses, in acceptance order.
- A write accepted at T followed by a read of the same address accepted at T+1: the read returns the new data, because the memory write completes at T+1 before the read executes at T+2.
- Simultaneous requests from all PEs are granted one per cycle in rotating order. No PE waits more than `N_PE-1` cycles.

## Configuration
Macro `SHMEM_ARB_BOUNDS_CHECK_EN`:
- Defined: an accepted request with `req_addr >= MEM_DEPTH` issues no `mem_read`/`mem_write`. Its response still pulses at T+2 with `resp_err`=1 and `resp_rdata`=0. The transfer still updates `last_grant`.
- Undefined: the address is passed to `mem_address` unchanged and `resp_err` is tied to 0.

## Test plan
- Reset: hold `rst` 3 cycles with all `req_valid`=1 -> `req_ready`, `mem_read`, `mem_write` and `resp_valid` are 0 throughout. The first grant after release goes to PE0.
- PE2 writes 0xDEADBEEF to addr 5 at edge T, then reads addr 5 at T+1 -> write ack `resp_valid[2]` at T+2 with `resp_rdata`=0. At T+3, `resp_valid[2]` pulses with `resp_rdata`=0xDEADBEEF.
- All 4 PEs hold valid reads of addresses 10..13 -> grants in order PE0,1,2,3,0. Responses arrive 2 cycles after each grant with matching data.
- PE1 only requests for 3 consecutive cycles -> PE1 is granted every cycle and `mem_read` stays high for 3 cycles.
- Read addr 300 -> with the macro: `resp_err`=1, `resp_rdata`=0, `mem_read` never asserted. Without the macro: `mem_address`=300 and `resp_err`=0.
- Reset asserted at T+1 after accepting a read at T -> no `resp_valid` at T+2 or later.

Source files
------------

// File: rtl/shared_mem_arbiter_if.sv
// rtl/shared_mem_arbiter_if.sv - PE request/response and memory command bundle for shared_mem_arbiter
interface shared_mem_arbiter_if #(
  parameter int N_PE   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [N_PE-1:0]        req_valid;
  logic [N_PE-1:0]        req_ready;
  logic [N_PE-1:0]        req_write;
  logic [N_PE*ADDR_W-1:0] req_addr;
  logic [N_PE*DATA_W-1:0] req_wdata;
  logic [N_PE-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   resp_err;
  logic [ADDR_W-1:0]      mem_address;
  logic [DATA_W-1:0]      mem_write_data;
  logic                   mem_read;
  logic                   mem_write;
  logic [DATA_W-1:0]      mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin N_PE arbiter in front of single-port shared memory, 2-cycle pipelined
// Optional address bounds checking: SHMEM_ARB_BOUNDS_CHECK_EN
module shared_mem_arbiter #(
  parameter int N_PE      = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input logic                 clk,
  input logic                 rst,
  shared_mem_arbiter_if.slave bus
);
  localparam int PTR_W = (N_PE > 1) ? $clog2(N_PE) : 1;
`ifdef SHMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  logic [PTR_W-1:0]  last_grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_found;
  logic              transfer;
  logic              sel_write;
  logic              sel_oob;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  int                cand;

  logic              s1_valid, s1_wr, s1_err;
  logic [PTR_W-1:0]  s1_idx;
  logic              s2_valid, s2_wr, s2_err;
  logic [PTR_W-1:0]  s2_idx;

  // Scan starts just after the last winner and wraps, so every PE waits at most N_PE-1 grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N_PE; k++) begin
      cand = (int'(last_grant) + k) % N_PE;
      if (!grant_found && bus.req_valid[PTR_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  assign transfer      = grant_found && !rst;
  assign bus.req_ready = transfer ? (N_PE'(1) << grant_idx) : '0;
  assign sel_write     = bus.req_write[grant_idx];
  assign sel_addr      = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata     = bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_oob       = BOUNDS_EN && ({1'b0, sel_addr} >= DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant         <= PTR_W'(N_PE-1);
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      s1_valid           <= 1'b0;
      s1_wr              <= 1'b0;
      s1_err             <= 1'b0;
      s1_idx             <= '0;
      s2_valid           <= 1'b0;
      s2_wr              <= 1'b0;
      s2_err             <= 1'b0;
      s2_idx             <= '0;
    end else begin
      bus.mem_read  <= transfer && !sel_write && !sel_oob;
      bus.mem_write <= transfer && sel_write && !sel_oob;
      s1_valid      <= transfer;
      if (transfer) begin
        last_grant         <= grant_idx;
        bus.mem_address    <= sel_addr;
        bus.mem_write_data <= sel_wdata;
        s1_idx             <= grant_idx;
        s1_wr              <= sel_write;
        s1_err             <= sel_oob;
      end
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_wr    <= s1_wr;
      s2_err   <= s1_err;
    end
  end

  // Memory read data arrives in the same cycle the stage-2 tag is live.
  assign bus.resp_valid = s2_valid ? (N_PE'(1) << s2_idx) : '0;
  assign bus.resp_err   = s2_valid && s2_err;
  assign bus.resp_rdata = (s2_valid && !s2_wr && !s2_err) ? bus.mem_read_data : '0;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - self-checking bench for shared_mem_arbiter
module tb_shared_mem_arbiter;
  localparam int NP = 4;
`ifdef SHMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] mem_model [0:511];
  logic [31:0] ref_mem   [0:511];
  exp_t        sb [$];
  vec_t        vec [$];

  logic        prev_grant = 1'b0;
  logic        prev_wr = 1'b0;
  logic        prev_oob = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  shared_mem_arbiter_if #(.N_PE(NP), .DATA_W(32), .ADDR_W(32)) bus ();

  shared_mem_arbiter #(.N_PE(NP), .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk) begin
    if (bus.mem_write) mem_model[bus.mem_address[8:0]] <= bus.mem_write_data;
    if (bus.mem_read)  bus.mem_read_data <= mem_model[bus.mem_address[8:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] write,
                              input logic [31:0] base, input logic [31:0] wdata,
                              input logic [3:0] exp_ready);
    vec_t v;
    v.valid = valid; v.write = write; v.base = base; v.wdata = wdata; v.exp_ready = exp_ready;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid != 4'b0 || (sb.size() > 0 && sb[0].due == edge_n)) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'(bus.resp_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("resp_time", 64'(edge_n), 64'(e.due));
        check("resp_valid", 64'(bus.resp_valid), 64'(4'b0001 << e.idx));
        check("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
        check("resp_err", 64'(bus.resp_err), 64'(e.err));
      end
    end
  end

  // Drives one cycle of requests, checks ready and the previous cycle's memory command, then advances.
  task automatic do_row(input vec_t v);
    int          idx;
    logic [31:0] a;
    logic        oob;
    exp_t        e;
    bus.req_valid = v.valid;
    bus.req_write = v.write;
    for (int i = 0; i < NP; i++) begin
      bus.req_addr[i*32 +: 32]  = v.base + 32'(i);
      bus.req_wdata[i*32 +: 32] = v.wdata;
    end
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(v.exp_ready));
    check("mem_read", 64'(bus.mem_read), 64'(prev_grant && !prev_wr && !prev_oob));
    check("mem_write", 64'(bus.mem_write), 64'(prev_grant && prev_wr && !prev_oob));
    if (prev_grant && !prev_oob) check("mem_address", 64'(bus.mem_address), 64'(prev_addr));
    if (prev_grant && prev_wr && !prev_oob) check("mem_wdata", 64'(bus.mem_write_data), 64'(prev_wdata));
    prev_grant = (v.exp_ready != 4'b0);
    if (prev_grant) begin
      idx = 0;
      for (int i = 0; i < NP; i++) if (v.exp_ready[i]) idx = i;
      a   = v.base + 32'(idx);
      oob = BC && (a >= 32'd256);
      e.due = edge_n + 2;
      e.idx = idx;
      e.err = oob;
      e.rdata = (v.write[idx] || oob) ? 32'h0 : ref_mem[a[8:0]];
      if (v.write[idx] && !oob) ref_mem[a[8:0]] = v.wdata;
      sb.push_back(e);
      prev_wr = v.write[idx]; prev_oob = oob; prev_addr = a; prev_wdata = v.wdata;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_model[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i]   = 32'hA500_0000 | 32'(i);
    end
    bus.mem_read_data = '0;
    bus.req_valid = 4'b1111;
    bus.req_write = 4'b0000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    vec.push_back(mk(4'b1111, 4'b0000, 32'd10, 32'd0, 4'b0001));
    vec.push_back(mk(4'b1111, 4'b0000, 32'd10, 32'd0, 4'b0010));
    vec.push_back(mk(4'b1111, 4'b0000, 32'd10, 32'd0, 4'b0100));
    vec.push_back(mk(4'b1111, 4'b0000, 32'd10, 32'd0, 4'b1000));
    vec.push_back(mk(4'b1111, 4'b0000, 32'd10, 32'd0, 4'b0001));
    vec.push_back(mk(4'b0000, 4'b0000, 32'd0,  32'd0, 4'b0000));
    vec.push_back(mk(4'b0100, 4'b0100, 32'd3,  32'hDEADBEEF, 4'b0100));
    vec.push_back(mk(4'b0100, 4'b0000, 32'd3,  32'd0, 4'b0100));
    vec.push_back(mk(4'b0010, 4'b0000, 32'd20, 32'd0, 4'b0010));
    vec.push_back(mk(4'b0010, 4'b0000, 32'd20, 32'd0, 4'b0010));
    vec.push_back(mk(4'b0010, 4'b0000, 32'd20, 32'd0, 4'b0010));
    vec.push_back(mk(4'b1011, 4'b0000, 32'd0,  32'd0, 4'b1000));
    vec.push_back(mk(4'b1011, 4'b0000, 32'd0,  32'd0, 4'b0001));
    vec.push_back(mk(4'b1011, 4'b0000, 32'd0,  32'd0, 4'b0010));
    vec.push_back(mk(4'b1000, 4'b0000, 32'd297, 32'd0, 4'b1000));
    vec.push_back(mk(4'b0000, 4'b0000, 32'd0,  32'd0, 4'b0000));
    vec.push_back(mk(4'b0000, 4'b0000, 32'd0,  32'd0, 4'b0000));

    // Reset held three cycles with every PE requesting.
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_mem_read", 64'(bus.mem_read), 64'(0));
      check("rst_mem_write", 64'(bus.mem_write), 64'(0));
      check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    end
    rst = 1'b0;

    foreach (vec[r]) do_row(vec[r]);

    // Reset one cycle after an accepted read drops it.
    do_row(mk(4'b0001, 4'b0000, 32'd7, 32'd0, 4'b0001));
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    sb.delete();
    prev_grant = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      check("drop_resp_valid", 64'(bus.resp_valid), 64'(0));
      @(negedge clk); #1;
    end

    do_row(mk(4'b1111, 4'b0000, 32'd40, 32'd0, 4'b0001));
    repeat (3) do_row(mk(4'b0000, 4'b0000, 32'd0, 32'd0, 4'b0000));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
